// File: rtl/bp_me_latency_shaper.sv
// Multi-channel programmable-latency delay with locked round-robin merge onto a single output.
// Each channel is a circular FIFO whose entries carry their own countdown to eligibility.

module bp_me_latency_shaper_chan #(
    parameter int width_p = 64,
    parameter int els_p   = 4,
    parameter int lat_w   = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               enq_i,
    input  logic [width_p-1:0] data_i,
    input  logic [lat_w-1:0]   lat_i,
    input  logic               deq_i,
    output logic               full_o,
    output logic               elig_n_o,
    output logic [width_p-1:0] head_n_o
);
    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    logic [els_p-1:0][width_p-1:0] mem;
    logic [els_p-1:0][lat_w-1:0]   cd;
    logic [ptr_w-1:0]              rd, wr, rd_n;
    logic [cnt_w-1:0]              cnt, cnt_n;
    logic                          head_new;

    function automatic logic [ptr_w-1:0] wrap_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o   = (cnt == cnt_w'(els_p));
    assign rd_n     = deq_i ? wrap_inc(rd) : rd;
    assign cnt_n    = cnt + cnt_w'(enq_i) - cnt_w'(deq_i);
    // The entry being written is the next head only when the FIFO drains to empty this edge.
    assign head_new = enq_i && (wr == rd_n);
    // Eligibility as it will be after this edge, so the registered grant lines up with countdown==0.
    assign elig_n_o = (cnt_n != '0) &&
                      (head_new ? (lat_i == '0) : (cd[rd_n] <= lat_w'(1)));
    assign head_n_o = head_new ? data_i : mem[rd_n];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
            cd  <= '0;
        end else begin
            rd  <= rd_n;
            cnt <= cnt_n;
            if (enq_i) wr <= wrap_inc(wr);
            for (int i = 0; i < els_p; i++) begin
                if (enq_i && (wr == ptr_w'(i))) cd[i] <= lat_i;
                else if (cd[i] != '0)           cd[i] <= cd[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_i) mem[wr] <= data_i;
    end
endmodule

module bp_me_latency_shaper #(
    parameter  int num_chan_p    = 2,
    parameter  int width_p       = 64,
    parameter  int els_p         = 4,
    parameter  int max_latency_p = 255,
    localparam int lat_w         = $clog2(max_latency_p + 1),
    localparam int chan_w        = (num_chan_p > 1) ? $clog2(num_chan_p) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [lat_w-1:0]              latency_i,
    input  logic [num_chan_p*width_p-1:0] data_i,
    input  logic [num_chan_p-1:0]         v_i,
    output logic [num_chan_p-1:0]         ready_o,
    output logic [width_p-1:0]            data_o,
    output logic [chan_w-1:0]             chan_o,
    output logic                          v_o,
    input  logic                          yumi_i
);
    logic                                rdy_en;
    logic [lat_w-1:0]                    lat_clamp;
    logic [num_chan_p-1:0]               full, elig_n;
    logic [num_chan_p-1:0][width_p-1:0]  head_n;
    logic                                pop, sel_v;
    logic [chan_w-1:0]                   rr, base, sel;

    function automatic logic [chan_w-1:0] next_chan(input logic [chan_w-1:0] c);
        return (c == chan_w'(num_chan_p - 1)) ? '0 : c + 1'b1;
    endfunction

    assign lat_clamp = (int'(latency_i) > max_latency_p) ? lat_w'(max_latency_p) : latency_i;
    assign pop       = yumi_i & v_o;
    assign base      = pop ? next_chan(chan_o) : rr;

    for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
        assign ready_o[c] = rdy_en & ~full[c];
        bp_me_latency_shaper_chan #(
            .width_p(width_p), .els_p(els_p), .lat_w(lat_w)
        ) u_chan (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .enq_i    (v_i[c] & ready_o[c]),
            .data_i   (data_i[c*width_p +: width_p]),
            .lat_i    (lat_clamp),
            .deq_i    (pop && (chan_o == chan_w'(c))),
            .full_o   (full[c]),
            .elig_n_o (elig_n[c]),
            .head_n_o (head_n[c])
        );
    end

    always_comb begin
        sel_v = 1'b0;
        sel   = base;
        for (int i = 0; i < num_chan_p; i++) begin
            if (!sel_v && elig_n[(int'(base) + i) % num_chan_p]) begin
                sel_v = 1'b1;
                sel   = chan_w'((int'(base) + i) % num_chan_p);
            end
        end
    end

    // v_o doubles as the grant lock: a new grant is only taken when idle or on acceptance.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rdy_en <= 1'b0;
            v_o    <= 1'b0;
            data_o <= '0;
            chan_o <= '0;
            rr     <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (pop) rr <= next_chan(chan_o);
            if (!v_o || pop) begin
                v_o <= sel_v;
                if (sel_v) begin
                    chan_o <= sel;
                    data_o <= head_n[sel];
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
`endif
endmodule

// File: tb/tb_bp_me_latency_shaper.sv
// Directed bench for bp_me_latency_shaper: stimulus pushes expected {data, chan, cycle}
// into a scoreboard that a negedge monitor drains on every accepted output.

module tb_bp_me_latency_shaper;
    localparam int N  = 2;
    localparam int W  = 64;
    localparam int E  = 4;
    localparam int ML = 200;
    localparam int LW = $clog2(ML + 1);

    logic            clk_i = 1'b0;
    logic            reset_n_i = 1'b1;
    logic [LW-1:0]   latency_i = '0;
    logic [N*W-1:0]  data_i = '0;
    logic [N-1:0]    v_i = '0;
    logic [N-1:0]    ready_o;
    logic [W-1:0]    data_o;
    logic [0:0]      chan_o;
    logic            v_o;
    logic            yumi_i;
    logic            yumi_en = 1'b0;

    assign yumi_i = yumi_en & v_o;

    bp_me_latency_shaper #(
        .num_chan_p(N), .width_p(W), .els_p(E), .max_latency_p(ML)
    ) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .latency_i(latency_i),
        .data_i   (data_i),
        .v_i      (v_i),
        .ready_o  (ready_o),
        .data_o   (data_o),
        .chan_o   (chan_o),
        .v_o      (v_o),
        .yumi_i   (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    typedef struct {
        logic [W-1:0] d;
        int           c;
        int           cy;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   tests = 0;
    int   fails = 0;

    always @(negedge clk_i) begin
        if (reset_n_i && v_o && yumi_i) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got data %0h chan %0d cycle %0d, expected none",
                         data_o, chan_o, cyc);
            end else begin
                m_e = q.pop_front();
                if (data_o !== m_e.d || chan_o !== 1'(m_e.c) || cyc != m_e.cy) begin
                    fails++;
                    $display("FAIL accept: got data %0h chan %0d cycle %0d, expected data %0h chan %0d cycle %0d",
                             data_o, chan_o, cyc, m_e.d, m_e.c, m_e.cy);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input int c, input int cy);
        q.push_back('{d: d, c: c, cy: cy});
    endtask

    task automatic enq(input int c, input logic [W-1:0] d, input int lat);
        v_i = '0;
        v_i[c] = 1'b1;
        data_i[c*W +: W] = d;
        latency_i = LW'(lat);
        tick();
        v_i = '0;
    endtask

    initial begin
        int t;
        logic hold_ok;

        // reset state
        #2 reset_n_i = 1'b0;
        tick(); tick();
        check("rst_ready", W'(ready_o), '0);
        check("rst_v", W'(v_o), '0);
        check("rst_data", data_o, '0);
        check("rst_chan", W'(chan_o), '0);
        reset_n_i = 1'b1;
        tick();
        check("ready_after_release", W'(ready_o), W'(2'b11));

        // latency 0: visible the cycle after enqueue, gone after yumi
        yumi_en = 1'b1;
        t = cyc;
        push(64'hA5, 0, t + 1);
        enq(0, 64'hA5, 0);
        check("lat0_v", W'(v_o), W'(1'b1));
        tick();
        check("lat0_v_drop", W'(v_o), '0);

        // latency 20, three back-to-back messages on chan 1
        t = cyc;
        push(64'h1, 1, t + 21);
        push(64'h2, 1, t + 22);
        push(64'h3, 1, t + 23);
        enq(1, 64'h1, 20);
        enq(1, 64'h2, 20);
        enq(1, 64'h3, 20);
        repeat (25) tick();

        // fill chan 0, stall 300 cycles, then drain
        yumi_en = 1'b0;
        t = cyc;
        for (int k = 0; k < 4; k++) push(W'(64'h10 + k), 0, t + 304 + k);
        for (int k = 0; k < 4; k++) enq(0, W'(64'h10 + k), 2);
        check("full_ready0", W'(ready_o[0]), '0);
        hold_ok = 1'b1;
        repeat (300) begin
            if (!(v_o === 1'b1 && data_o === 64'h10 && chan_o === 1'b0)) hold_ok = 1'b0;
            tick();
        end
        check("stall_hold", W'(hold_ok), W'(1'b1));
        yumi_en = 1'b1;
        tick();
        check("ready0_after_yumi", W'(ready_o[0]), W'(1'b1));
        repeat (6) tick();

        // both channels eligible every cycle: rr pointer sits at 1 after the chan 0 drain
        t = cyc;
        for (int k = 0; k < 4; k++) begin
            push(W'(64'h30 + k), 1, t + 4 + 2*k);
            push(W'(64'h20 + k), 0, t + 5 + 2*k);
        end
        for (int k = 0; k < 4; k++) begin
            v_i = 2'b11;
            data_i = {W'(64'h30 + k), W'(64'h20 + k)};
            latency_i = LW'(3);
            tick();
        end
        v_i = '0;
        repeat (10) tick();

        // grant lock: chan 1 becomes eligible (and has priority) while chan 0 is held
        yumi_en = 1'b0;
        t = cyc;
        push(64'h40, 0, t + 6);
        push(64'h50, 1, t + 7);
        enq(0, 64'h40, 0);
        enq(1, 64'h50, 0);
        hold_ok = 1'b1;
        repeat (4) begin
            if (!(v_o === 1'b1 && data_o === 64'h40 && chan_o === 1'b0)) hold_ok = 1'b0;
            tick();
        end
        check("lock_hold", W'(hold_ok), W'(1'b1));
        yumi_en = 1'b1;
        repeat (4) tick();

        // latency above max_latency_p clamps to it
        t = cyc;
        push(64'hC1, 1, t + 1 + ML);
        enq(1, 64'hC1, 250);
        repeat (ML + 5) tick();

        // async reset with messages held discards them
        yumi_en = 1'b0;
        enq(0, 64'hE0, 0);
        enq(0, 64'hE1, 0);
        enq(0, 64'hE2, 0);
        check("pre_reset_v", W'(v_o), W'(1'b1));
        #2 reset_n_i = 1'b0;
        #1;
        check("async_rst_v", W'(v_o), '0);
        check("async_rst_ready", W'(ready_o), '0);
        tick(); tick();
        reset_n_i = 1'b1;
        tick();
        check("ready_after_rerelease", W'(ready_o), W'(2'b11));
        yumi_en = 1'b1;
        repeat (20) tick();
        check("no_stale_v", W'(v_o), '0);
        check("sb_drained", W'(q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
